// File: rtl/rr_enc16to4_if.sv
// Request/grant bundle for the round-robin 16-to-4 encoder.
// The master side presents requests and consumes grants; the slave side is the arbiter.
interface rr_enc16to4_if;
  logic        en;
  logic [15:0] req;
  logic        ready;
  logic        valid;
  logic [3:0]  code;
  logic [0:15] grant;

  modport master (
    output en,
    output req,
    output ready,
    input  valid,
    input  code,
    input  grant
  );

  modport slave (
    input  en,
    input  req,
    input  ready,
    output valid,
    output code,
    output grant
  );
endinterface

// File: rtl/rr_enc16to4.sv
// Round-robin 16-to-4 priority encoder with a valid/ready grant handshake.
// The search starts one past the last accepted index. A grant is held,
// sticky, until the consumer takes it. Back-to-back grants are issued on
// handshake cycles.
module rr_enc16to4 (
  input  logic          clock,
  input  logic          reset,
  rr_enc16to4_if.slave  bus
);
  localparam int N     = 16;
  localparam int IDX_W = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       state_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] code_reg;
  logic [0:N-1]     grant_reg;

  // A new search begins at the pointer when idle. On a handshake it begins
  // one past the grant being accepted, which is the pointer's next value.
  logic [IDX_W-1:0] code_inc;
  logic [IDX_W-1:0] search_start;
  logic             req_any;

  assign code_inc     = code_reg + 4'd1;
  assign search_start = (state_reg == ST_HOLD) ? code_inc : ptr_reg;
  assign req_any      = |bus.req;

  // Rotate the requests right by search_start so the first candidate sits at
  // bit 0. Rotate the one-hot pick back left by the same amount. Each is a
  // log-depth barrel rotator, one stage per bit of the start index.
  logic [N-1:0] rot_r [IDX_W+1];
  logic [N-1:0] rot_l [IDX_W+1];
  logic [N-1:0] pick_rot;
  logic [N-1:0] lower_any;
  logic [N-1:0] win_oh;

  assign rot_r[0] = bus.req;
  assign rot_l[0] = pick_rot;

  genvar gi;
  generate
    for (gi = 0; gi < IDX_W; gi++) begin : g_rot
      localparam int SH = 1 << gi;
      assign rot_r[gi+1] = search_start[gi] ?
                           {rot_r[gi][SH-1:0], rot_r[gi][N-1:SH]} : rot_r[gi];
      assign rot_l[gi+1] = search_start[gi] ?
                           {rot_l[gi][N-SH-1:0], rot_l[gi][N-1:N-SH]} : rot_l[gi];
    end

    // Lowest set bit of the rotated request vector wins.
    assign lower_any[0] = 1'b0;
    for (gi = 0; gi < N; gi++) begin : g_pick
      assign pick_rot[gi] = rot_r[IDX_W][gi] & ~lower_any[gi];
      if (gi < N - 1) begin : g_chain
        assign lower_any[gi+1] = lower_any[gi] | rot_r[IDX_W][gi];
      end
    end
  endgenerate

  assign win_oh = rot_l[IDX_W];

  // Convert the one-hot winner into its binary index.
  logic [IDX_W-1:0] win_code;
  always_comb begin
    win_code = '0;
    for (int i = 0; i < N; i++) begin
      if (win_oh[i]) begin
        win_code = win_code | IDX_W'(i);
      end
    end
  end

  // The grant bus is indexed [0:N-1], so copy bit by bit to keep grant[i] == index i.
  logic [0:N-1] win_grant;
  generate
    for (gi = 0; gi < N; gi++) begin : g_grant
      assign win_grant[gi] = win_oh[gi];
    end
  endgenerate

  // Grant FSM: issue from IDLE, hold until ready, and chain on the handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      code_reg  <= '0;
      grant_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.en && req_any) begin
            code_reg  <= win_code;
            grant_reg <= win_grant;
            state_reg <= ST_HOLD;
          end
        end
        default: begin
          if (bus.ready) begin
            ptr_reg <= code_inc;
            if (bus.en && req_any) begin
              code_reg  <= win_code;
              grant_reg <= win_grant;
            end else begin
              grant_reg <= '0;
              state_reg <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign bus.valid = (state_reg == ST_HOLD);
  assign bus.code  = code_reg;
  assign bus.grant = grant_reg;
endmodule

// File: tb/tb_rr_enc16to4.sv
// Bench for rr_enc16to4: vector table, hand-written sticky/reset sequences,
// and random traffic against a reference arbiter model.
module tb_rr_enc16to4;
  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  rr_enc16to4_if bus ();

  rr_enc16to4 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        en;
    logic [15:0] req;
    logic        rdy;
    logic        ev;
    logic [3:0]  ec;
    int          tag;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic e, input logic [15:0] q,
                              input logic rd, input logic ev, input logic [3:0] ec,
                              input int tag);
    vec_t v;
    v.rst = r; v.en = e; v.req = q; v.rdy = rd; v.ev = ev; v.ec = ec; v.tag = tag;
    vecs.push_back(v);
  endfunction

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic cyc(input logic r, input logic e, input logic [15:0] q, input logic rd);
    reset     = r;
    bus.en    = e;
    bus.req   = q;
    bus.ready = rd;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic ev, input logic [3:0] ec);
    logic [0:15] eg;
    eg = '0;
    if (ev) eg[ec] = 1'b1;
    $display("[%0t] %s rst=%0b en=%0b req=%h rdy=%0b -> valid=%0b code=%0d grant=%h",
             $time, name, reset, bus.en, bus.req, bus.ready, bus.valid, bus.code, bus.grant);
    checks++;
    if (bus.valid !== ev) begin
      errors++;
      $display("FAIL %s valid: got %0b expected %0b", name, bus.valid, ev);
    end
    checks++;
    if (bus.code !== ec) begin
      errors++;
      $display("FAIL %s code: got %0d expected %0d", name, bus.code, ec);
    end
    checks++;
    if (bus.grant !== eg) begin
      errors++;
      $display("FAIL %s grant: got %h expected %h", name, bus.grant, eg);
    end
  endtask

  // Reference: first set request walking upward from start, modulo 16.
  function automatic logic [3:0] ref_pick(input logic [15:0] q, input logic [3:0] start);
    for (int k = 0; k < 16; k++) begin
      int idx;
      idx = (int'(start) + k) % 16;
      if (q[idx]) return 4'(idx);
    end
    return 4'd0;
  endfunction

  // Reference arbiter state.
  logic       m_valid;
  logic [3:0] m_code;
  logic [3:0] m_ptr;

  task automatic model_step(input logic r, input logic e, input logic [15:0] q, input logic rd);
    if (r) begin
      m_valid = 1'b0; m_code = 4'd0; m_ptr = 4'd0;
    end else if (!m_valid) begin
      if (e && q != 16'h0) begin
        m_code  = ref_pick(q, m_ptr);
        m_valid = 1'b1;
      end
    end else if (rd) begin
      m_ptr = 4'((int'(m_code) + 1) % 16);
      if (e && q != 16'h0) m_code = ref_pick(q, m_ptr);
      else                 m_valid = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; bus.en = 1'b0; bus.req = '0; bus.ready = 1'b0;

    // T1: reset, then no requests with ready high.
    add(1, 0, 16'h0000, 0, 0, 0, 1);
    add(1, 0, 16'h0000, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) add(0, 1, 16'h0000, 1, 0, 0, 1);
    // T2: two requesters alternate.
    add(0, 1, 16'h0208, 1, 1, 3, 2);
    add(0, 1, 16'h0208, 1, 1, 9, 2);
    add(0, 1, 16'h0208, 1, 1, 3, 2);
    add(0, 1, 16'h0208, 1, 1, 9, 2);
    // T3: pointer wrap 15 -> 0.
    add(1, 0, 16'h0000, 0, 0, 0, 3);
    add(0, 1, 16'h8001, 1, 1, 0, 3);
    add(0, 1, 16'h8001, 1, 1, 15, 3);
    add(0, 1, 16'h8001, 1, 1, 0, 3);
    add(0, 1, 16'h8001, 1, 1, 15, 3);
    // T6: enable gating.
    add(1, 0, 16'h0000, 0, 0, 0, 6);
    for (int i = 0; i < 4; i++) add(0, 0, 16'h0400, 1, 0, 0, 6);
    add(0, 1, 16'h0400, 1, 1, 10, 6);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].rdy);
      check($sformatf("T%0d#%0d", vecs[i].tag, i), vecs[i].ev, vecs[i].ec);
    end

    // T4: sticky grant while ready is low, even after the request drops.
    cyc(1, 0, 16'h0000, 0);
    check("T4_reset", 0, 0);
    cyc(0, 1, 16'h0020, 0);
    check("T4_grant", 1, 5);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, (i == 0) ? 16'h0020 : 16'h0000, 0);
      check($sformatf("T4_hold%0d", i), 1, 5);
    end
    cyc(0, 1, 16'h0000, 1);
    check("T4_accept", 0, 5);
    cyc(0, 1, 16'h0000, 1);
    check("T4_idle", 0, 5);

    // T5: reset in the middle of a held grant restarts the pointer.
    cyc(1, 0, 16'h0000, 0);
    check("T5_reset0", 0, 0);
    cyc(0, 1, 16'h00F0, 1);
    check("T5_g4", 1, 4);
    cyc(0, 1, 16'h00F0, 1);
    check("T5_g5", 1, 5);
    cyc(0, 1, 16'h00F0, 1);
    check("T5_g6", 1, 6);
    cyc(0, 1, 16'h00F0, 0);
    check("T5_hold6", 1, 6);
    cyc(1, 1, 16'h00F0, 0);
    check("T5_reset", 0, 0);
    cyc(0, 1, 16'h00F0, 1);
    check("T5_restart", 1, 4);

    // Random traffic against the reference model.
    cyc(1, 0, 16'h0000, 0);
    model_step(1, 0, 16'h0000, 0);
    check("RND_reset", m_valid, m_code);
    for (int i = 0; i < 600; i++) begin
      logic        r, e, rd;
      logic [15:0] q;
      int          kind;
      r    = ($urandom_range(0, 99) == 0);
      e    = ($urandom_range(0, 9) != 0);
      rd   = ($urandom_range(0, 2) != 0);
      kind = $urandom_range(0, 3);
      case (kind)
        0:       q = 16'h0000;
        1:       q = 16'h0001 << $urandom_range(0, 15);
        2:       q = 16'($urandom) & 16'($urandom) & 16'($urandom);
        default: q = 16'($urandom);
      endcase
      model_step(r, e, q, rd);
      cyc(r, e, q, rd);
      check($sformatf("RND#%0d", i), m_valid, m_code);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
